graphics_draw_control: RTL

Control sequencer that sits directly upstream of `graphics_datapath`. It accepts one 8x8 block-draw command at a time from game logic over a valid/ready handshake. It then drives the datapath's `load`/`enable`/`flash` controls and the VGA adapter's plot strobe, so that exactly 64 pixels are written per block. Flash commands draw the block white, hold for a programmable time, then redraw it in its real colour.

---
 rtl/graphics_draw_control.sv | 139 +++++++++++++
 1 files changed

// File: rtl/graphics_draw_control.sv
// graphics_draw_control
// Sequences one 8x8 block-draw command at a time into graphics_datapath and
// strobes the VGA adapter's plot input so that exactly 64 pixels are written.
// A flash command draws the block white first, holds for FLASH_HOLD cycles,
// and then redraws the block in its real colour.
//
// Ports
//   clock, reset        : system clock, synchronous active-high reset
//   req_valid/req_ready : command handshake (ready only while idle)
//   req_x, req_y        : block origin
//   req_colour          : block colour
//   req_flash           : 1 = flash-then-draw command
//   dp_load/dp_enable   : datapath register load / counter enable
//   dp_flash            : datapath white-override for the first pass
//   dp_x/dp_y/dp_colour : latched command, presented to the datapath
//   plot                : VGA adapter write enable
//   busy                : command in progress
//   done                : one-cycle pulse on command completion
module graphics_draw_control #(
  parameter logic [23:0] FLASH_HOLD = 24'd12_500_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_x,
  input  logic [7:0] req_y,
  input  logic [2:0] req_colour,
  input  logic       req_flash,
  output logic       dp_load,
  output logic       dp_enable,
  output logic       dp_flash,
  output logic [7:0] dp_x,
  output logic [7:0] dp_y,
  output logic [2:0] dp_colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam int unsigned PC_W = 6;
  localparam int unsigned HC_W = 24;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    DRAW = 3'd2,
    HOLD = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [HC_W-1:0] hc;
  logic            ph;
  logic            cmd_flash;

  // Moore output pattern of a state: {load, enable, flash, plot, busy, done}.
  // Loaded alongside the state so the registered outputs track the state.
  function automatic logic [5:0] strobes(input state_t s, input logic white);
    case (s)
      LOAD:    strobes = {1'b1, 1'b1, white, 1'b0, 1'b1, 1'b0};
      DRAW:    strobes = 6'b010110;
      HOLD:    strobes = 6'b000010;
      DONE:    strobes = 6'b000011;
      default: strobes = 6'b000000;
    endcase
  endfunction

  // Ready is the only combinational output; it drops while reset is held.
  assign req_ready = (state == IDLE) && !reset;

  // Sequencer state, counters, command register and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= '0;
      hc        <= '0;
      ph        <= 1'b0;
      cmd_flash <= 1'b0;
      dp_x      <= '0;
      dp_y      <= '0;
      dp_colour <= '0;
      {dp_load, dp_enable, dp_flash, plot, busy, done} <= 6'b000000;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            dp_x      <= req_x;
            dp_y      <= req_y;
            dp_colour <= req_colour;
            cmd_flash <= req_flash;
            ph        <= 1'b0;
            state     <= LOAD;
            {dp_load, dp_enable, dp_flash, plot, busy, done} <= strobes(LOAD, req_flash);
          end
        end
        LOAD: begin
          pc    <= '0;
          state <= DRAW;
          {dp_load, dp_enable, dp_flash, plot, busy, done} <= strobes(DRAW, 1'b0);
        end
        DRAW: begin
          pc <= pc + PC_W'(1);
          if (pc == PC_W'(63)) begin
            // Only the white pass of a flash command is followed by a hold.
            if (cmd_flash && !ph) begin
              hc    <= '0;
              state <= HOLD;
              {dp_load, dp_enable, dp_flash, plot, busy, done} <= strobes(HOLD, 1'b0);
            end else begin
              state <= DONE;
              {dp_load, dp_enable, dp_flash, plot, busy, done} <= strobes(DONE, 1'b0);
            end
          end
        end
        HOLD: begin
          if (hc == FLASH_HOLD - HC_W'(1)) begin
            // Redraw pass: ph=1 so the reload carries the true colour.
            ph    <= 1'b1;
            state <= LOAD;
            {dp_load, dp_enable, dp_flash, plot, busy, done} <= strobes(LOAD, 1'b0);
          end else begin
            hc <= hc + HC_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          {dp_load, dp_enable, dp_flash, plot, busy, done} <= strobes(IDLE, 1'b0);
        end
        default: begin
          state <= IDLE;
          {dp_load, dp_enable, dp_flash, plot, busy, done} <= 6'b000000;
        end
      endcase
    end
  end

endmodule
